// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA screen sequencer.
//   state_e : top-level display mode (normal play, lost screen, won screen)
//   evt_e   : end-of-game event latched while playing
//   merge_evt : folds new event pulses into the pending event, completed wins
package vga_seq_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        PLAY,
        OVER,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_OVER,
        EV_COMPLETED
    } evt_e;

    // Completed always wins; a pending completed is never downgraded to over.
    function automatic evt_e merge_evt(evt_e pend, logic over, logic completed);
        if (completed)
            return EV_COMPLETED;
        if (pend == EV_COMPLETED)
            return pend;
        if (over)
            return EV_OVER;
        return pend;
    endfunction

endpackage

// File: rtl/vga_screen_sequencer_if.sv
// Game-logic side of the screen sequencer: board-update handshake plus the
// single-cycle game events.
//   upd_valid/upd_vals/upd_ready : valid/ready transfer of a 64-bit board image
//   evt_over/evt_completed/evt_restart : single-cycle event pulses
// master = game FSM, slave = sequencer.
interface vga_screen_sequencer_if;

    logic        upd_valid;
    logic [63:0] upd_vals;
    logic        upd_ready;
    logic        evt_over;
    logic        evt_completed;
    logic        evt_restart;

    modport master (
        output upd_valid, upd_vals, evt_over, evt_completed, evt_restart,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_vals, evt_over, evt_completed, evt_restart,
        output upd_ready
    );

endinterface

// File: rtl/vga_frame_tick.sv
// Frame tick and hold counter.
//   clk, rst             : pixel clock, async active-high reset
//   counter_x, counter_y : VGA timing counters
//   clr                  : clear the frame counter on the next commit
//   en                   : count commits (saturating at HOLD_FRAMES)
//   commit               : one-cycle pulse at the end of the last visible line
//   hold_reached         : counter has reached HOLD_FRAMES
module vga_frame_tick #(
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int HOLD_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       clr,
    input  logic       en,
    output logic       commit,
    output logic       hold_reached
);

    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

    logic [CNT_W-1:0] frame_cnt_reg;

    assign commit       = (counter_x == 10'(H_TOTAL - 1)) && (counter_y == 10'(V_ACTIVE - 1));
    assign hold_reached = (frame_cnt_reg == CNT_W'(HOLD_FRAMES));

    // Only commit edges touch the counter, so it steps once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (commit) begin
            if (clr)
                frame_cnt_reg <= '0;
            else if (en && !hold_reached)
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/vga_screen_sequencer.sv
// Frame-synchronous owner of the VGA display inputs. Board updates and
// win/lose/restart events from the game FSM are buffered and applied only on
// the commit pulse (end of last visible line), so a frame never shows a mixed
// image.
//   clk, rst             : pixel clock, async active-high reset
//   counter_x, counter_y : VGA timing counters
//   upd                  : game-side handshake/event interface (slave)
//   vals                 : committed board image
//   gameover             : committed lost-screen select
//   gamecompleted        : committed won-screen select
//   hold_done            : end screen shown for at least HOLD_FRAMES frames
import vga_seq_pkg::*;

module vga_screen_sequencer #(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int HOLD_FRAMES = 180
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             counter_x,
    input  logic [9:0]             counter_y,
    vga_screen_sequencer_if.slave  upd,
    output logic [63:0]            vals,
    output logic                   gameover,
    output logic                   gamecompleted,
    output logic                   hold_done
);

    state_e      state_reg, state_next;
    logic [63:0] vals_reg, vals_next;
    logic [63:0] shadow_reg, shadow_next;
    logic        shadow_full_reg, shadow_full_next;
    evt_e        pend_reg, pend_next;
    logic        restart_reg, restart_next;

    logic commit;
    logic hold_reached;
    logic cnt_clr;
    logic xfer;

    vga_frame_tick #(
        .H_TOTAL     (H_TOTAL),
        .V_ACTIVE    (V_ACTIVE),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .counter_x    (counter_x),
        .counter_y    (counter_y),
        .clr          (cnt_clr),
        .en           (state_reg != PLAY),
        .commit       (commit),
        .hold_reached (hold_reached)
    );

    // No new image is taken once an end event is pending: the pending
    // event freezes the board at whatever the shadow already holds.
    assign upd.upd_ready = (state_reg == PLAY) && !shadow_full_reg && (pend_reg == EV_NONE);
    assign xfer          = upd.upd_valid && upd.upd_ready;

    assign vals          = vals_reg;
    assign gameover      = (state_reg == OVER);
    assign gamecompleted = (state_reg == DONE);
    assign hold_done     = (state_reg != PLAY) && hold_reached;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= PLAY;
            vals_reg        <= '0;
            shadow_reg      <= '0;
            shadow_full_reg <= 1'b0;
            pend_reg        <= EV_NONE;
            restart_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            vals_reg        <= vals_next;
            shadow_reg      <= shadow_next;
            shadow_full_reg <= shadow_full_next;
            pend_reg        <= pend_next;
            restart_reg     <= restart_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        vals_next        = vals_reg;
        shadow_next      = shadow_reg;
        shadow_full_next = shadow_full_reg;
        pend_next        = pend_reg;
        restart_next     = restart_reg;
        cnt_clr          = 1'b0;

        case (state_reg)
            PLAY: begin
                // Events seen on the commit cycle itself take effect on that edge.
                pend_next = merge_evt(pend_reg, upd.evt_over, upd.evt_completed);
                if (xfer) begin
                    shadow_next      = upd.upd_vals;
                    shadow_full_next = 1'b1;
                end
                if (commit) begin
                    // A transfer on the commit cycle lands in the shadow only
                    // (xfer implies the shadow was empty, so nothing is lost).
                    if (shadow_full_reg) begin
                        vals_next        = shadow_reg;
                        shadow_full_next = xfer;
                    end
                    if (pend_next != EV_NONE) begin
                        state_next = (pend_next == EV_COMPLETED) ? DONE : OVER;
                        pend_next  = EV_NONE;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            OVER, DONE: begin
                if (hold_reached && upd.evt_restart)
                    restart_next = 1'b1;
                if (commit && restart_next) begin
                    state_next       = PLAY;
                    vals_next        = '0;
                    shadow_full_next = 1'b0;
                    restart_next     = 1'b0;
                    cnt_clr          = 1'b1;
                end
            end
            default: begin
                state_next = PLAY;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_screen_sequencer.sv
// Scoreboard bench for vga_screen_sequencer with HOLD_FRAMES=3. The stimulus
// drives the timing counters directly so each frame is only a few cycles;
// every commit pushes an expected display state that the monitor pops and
// compares after the commit edge.
module tb_vga_screen_sequencer;

    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  cx  = '0;
    logic [9:0]  cy  = '0;
    logic [63:0] vals;
    logic        go, gc, hd;

    vga_screen_sequencer_if bus ();

    vga_screen_sequencer #(.HOLD_FRAMES(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .counter_x     (cx),
        .counter_y     (cy),
        .upd           (bus),
        .vals          (vals),
        .gameover      (go),
        .gamecompleted (gc),
        .hold_done     (hd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] v;
        logic        go_e;
        logic        gc_e;
        logic        hd_e;
        logic        rdy_e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_frame  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every commit edge is a display transaction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst && cx == 10'd799 && cy == 10'd479) begin
                @(negedge clk);
                n_frame++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got commit %0d, expected none", n_frame);
                end else begin
                    e = sb.pop_front();
                    $display("frame %0d: vals=%h gameover=%b gamecompleted=%b hold_done=%b upd_ready=%b",
                             n_frame, vals, go, gc, hd, bus.upd_ready);
                    chk("frame_vals", vals, e.v);
                    chk("frame_gameover", 64'(go), 64'(e.go_e));
                    chk("frame_gamecompleted", 64'(gc), 64'(e.gc_e));
                    chk("frame_hold_done", 64'(hd), 64'(e.hd_e));
                    chk("frame_upd_ready", 64'(bus.upd_ready), 64'(e.rdy_e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [63:0] v, input logic go_e, gc_e, hd_e, rdy_e);
        sb.push_back('{v, go_e, gc_e, hd_e, rdy_e});
        cx = 10'd799;
        cy = 10'd479;
        cyc();
        cx = 10'd100;
        cy = 10'd200;
    endtask

    task automatic offer(input logic [63:0] v);
        bus.upd_valid = 1'b1;
        bus.upd_vals  = v;
        cyc();
        bus.upd_valid = 1'b0;
    endtask

    // Three hold frames (restart and over pulses ignored in the first two),
    // then a restart that returns to an empty play screen.
    task automatic hold_restart(input logic [63:0] v, input logic go_e, gc_e);
        for (int i = 0; i < HOLD; i++) begin
            if (i < 2) begin
                bus.evt_restart = 1'b1;
                bus.evt_over    = 1'b1;
            end
            cyc();
            bus.evt_restart = 1'b0;
            bus.evt_over    = 1'b0;
            frame(v, go_e, gc_e, (i == HOLD - 1), 1'b0);
        end
        bus.evt_restart = 1'b1;
        cyc();
        bus.evt_restart = 1'b0;
        frame(64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.upd_valid     = 1'b0;
        bus.upd_vals      = '0;
        bus.evt_over      = 1'b0;
        bus.evt_completed = 1'b0;
        bus.evt_restart   = 1'b0;
        repeat (3) cyc();
        chk("reset_vals", vals, 64'h0);
        chk("reset_gameover", 64'(go), 64'h0);
        chk("reset_gamecompleted", 64'(gc), 64'h0);
        chk("reset_hold_done", 64'(hd), 64'h0);
        chk("reset_upd_ready", 64'(bus.upd_ready), 64'h1);
        rst = 1'b0;
        cx  = 10'd100;
        cy  = 10'd200;
        cyc();

        // Single update accepted mid-frame, visible only after commit.
        offer(64'hA5A5_0000_0000_0001);
        chk("t1_ready_busy", 64'(bus.upd_ready), 64'h0);
        chk("t1_vals_hold", vals, 64'h0);
        repeat (3) cyc();
        chk("t1_vals_still", vals, 64'h0);
        frame(64'hA5A5_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);

        // Two updates in one frame: second waits for the commit.
        offer(64'h1);
        bus.upd_valid = 1'b1;
        bus.upd_vals  = 64'h2;
        cyc();
        chk("t2_ready_held", 64'(bus.upd_ready), 64'h0);
        chk("t2_vals_old", vals, 64'hA5A5_0000_0000_0001);
        frame(64'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        bus.upd_valid = 1'b0;
        chk("t2_second_taken", 64'(bus.upd_ready), 64'h0);
        frame(64'h2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Transfer on the commit cycle goes to the shadow only.
        bus.upd_valid = 1'b1;
        bus.upd_vals  = 64'h33;
        frame(64'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.upd_valid = 1'b0;
        frame(64'h33, 1'b0, 1'b0, 1'b0, 1'b1);

        // Both events together with FF in the shadow: completed wins.
        offer(64'hFF);
        bus.evt_over      = 1'b1;
        bus.evt_completed = 1'b1;
        cyc();
        bus.evt_over      = 1'b0;
        bus.evt_completed = 1'b0;
        chk("t3_ready_pending", 64'(bus.upd_ready), 64'h0);
        frame(64'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        hold_restart(64'hFF, 1'b0, 1'b1);

        // evt_over on the commit cycle applies on that edge; then hold in OVER.
        bus.evt_over = 1'b1;
        frame(64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.evt_over = 1'b0;
        hold_restart(64'h0, 1'b1, 1'b0);

        // Later completed overrides a pending over.
        bus.evt_over = 1'b1;
        cyc();
        bus.evt_over      = 1'b0;
        bus.evt_completed = 1'b1;
        cyc();
        bus.evt_completed = 1'b0;
        frame(64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        hold_restart(64'h0, 1'b0, 1'b1);

        // Later over does not override a pending completed; then async reset mid-hold.
        offer(64'h77);
        bus.evt_completed = 1'b1;
        cyc();
        bus.evt_completed = 1'b0;
        bus.evt_over      = 1'b1;
        cyc();
        bus.evt_over = 1'b0;
        frame(64'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(64'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(64'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(64'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_vals_async", vals, 64'h0);
        chk("t6_gamecompleted_async", 64'(gc), 64'h0);
        chk("t6_gameover_async", 64'(go), 64'h0);
        chk("t6_hold_done_async", 64'(hd), 64'h0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("t6_ready_after", 64'(bus.upd_ready), 64'h1);
        chk("t6_vals_after", vals, 64'h0);

        repeat (2) cyc();
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
